// File: rtl/axi4_lite_pkg.sv
// Shared types and width helpers for the AXI4-Lite register slave.
package axi4_lite_pkg;

  // AXI response codes used by this slave.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // Address bus width paired with a given data width (32 -> 32, 64 -> 64).
  function automatic int addr_width(input int dw);
    return dw;
  endfunction

  // Number of byte strobes for a given data width.
  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/axi4_lite_wr_buffer.sv
// Single-entry holding buffer: captures a payload on i_load, stays full until
// i_clear. Used to decouple the AW and W channels from the commit point.
module axi4_lite_wr_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Capture on load, release on clear; clear wins since a full buffer cannot load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end

  assign o_full  = r_full;
  assign o_ready = !r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS byte-writable registers, one outstanding
// write response and one outstanding read response.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both high; a source holds VALID and its payload stable
// until that edge, and READY never depends combinationally on VALID.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                   ADDR_WIDTH  = addr_width(DATA_WIDTH),
  localparam int                   STRB_WIDTH  = strb_width(DATA_WIDTH)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  input  logic [2:0]                     AWPROT,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [STRB_WIDTH-1:0]          WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  input  logic [2:0]                     ARPROT,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic                  r_rdy_en;
  logic                  r_bvalid;
  resp_t                 r_bresp;
  logic                  r_rvalid;
  resp_t                 r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_full, w_aw_ready, w_aw_load;
  logic                  w_w_full, w_w_ready, w_w_load;
  logic [ADDR_WIDTH-1:0] w_aw_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_WIDTH-1:0] w_wstrb;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_aw_idx, w_ar_idx;
  logic                  w_aw_hit, w_ar_hit, w_ar_hs;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  // Protection bits carry no meaning for this register bank.
  assign w_unused = &{1'b0, AWPROT, ARPROT};

  // Ready outputs stay low until the first edge after reset is released.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rdy_en <= 1'b0;
    else          r_rdy_en <= 1'b1;
  end

  assign AWREADY   = r_rdy_en & w_aw_ready;
  assign WREADY    = r_rdy_en & w_w_ready;
  assign ARREADY   = r_rdy_en & !r_rvalid;
  assign w_aw_load = AWVALID & AWREADY;
  assign w_w_load  = WVALID & WREADY;
  assign w_ar_hs   = ARVALID & ARREADY;
  assign w_commit  = w_aw_full & w_w_full & !r_bvalid;

  axi4_lite_wr_buffer #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_load  (w_aw_load),
    .i_clear (w_commit),
    .i_data  (AWADDR),
    .o_full  (w_aw_full),
    .o_ready (w_aw_ready),
    .o_data  (w_aw_addr)
  );

  axi4_lite_wr_buffer #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_buf (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_load  (w_w_load),
    .i_clear (w_commit),
    .i_data  ({WSTRB, WDATA}),
    .o_full  (w_w_full),
    .o_ready (w_w_ready),
    .o_data  ({w_wstrb, w_wdata})
  );

  // Full-width index compare so stray upper address bits land out of range.
  assign w_aw_idx = w_aw_addr >> ADDR_LSB;
  assign w_ar_idx = ARADDR >> ADDR_LSB;
  assign w_aw_hit = w_aw_idx < ADDR_WIDTH'(NUM_REGS);
  assign w_ar_hit = w_ar_idx < ADDR_WIDTH'(NUM_REGS);

  // Read mux; an index with no matching register yields zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == ADDR_WIDTH'(i)) w_rd_word = r_regs[i];
    end
  end

  // Register bank: byte-strobed update and one-cycle write pulse on commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_aw_idx == ADDR_WIDTH'(i)) begin
            r_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < STRB_WIDTH; b++) begin
              if (w_wstrb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Write response: raised by a commit, held until the master accepts it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_aw_hit ? OKAY : SLVERR;
    end else if (r_bvalid && BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read response: registered on AR handshake, held until the master accepts it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_ar_hit ? OKAY : SLVERR;
      r_rdata  <= w_rd_word;
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Flatten the register array for fabric-side consumers.
  always_comb begin
    reg_o = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

  assign wr_pulse_o = r_wr_pulse;
  assign BVALID     = r_bvalid;
  assign BRESP      = r_bresp;
  assign RVALID     = r_rvalid;
  assign RRESP      = r_rresp;
  assign RDATA      = r_rdata;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave (32-bit data, 16 registers, reset value 0).
module tb_axi4_lite_reg_slave;

  localparam int DW = 32;
  localparam int NR = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [31:0]   AWADDR, WDATA, ARADDR;
  logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [2:0]    AWPROT, ARPROT;
  logic [3:0]    WSTRB;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]    BRESP, RRESP;
  logic [31:0]   RDATA;
  logic [NR*DW-1:0] reg_o;
  logic [NR-1:0] wr_pulse_o;

  logic [NR*DW-1:0] exp_regs;
  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi4_lite_reg_slave #(.DATA_WIDTH(DW), .NUM_REGS(NR), .RESET_VALUE('0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
  );

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    ARADDR  = addr;
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    tick();
    ARVALID = 1'b0;
    chk({tag, "_rvalid"}, RVALID, 1'b1);
    chk({tag, "_rdata"}, RDATA, exp_data);
    chk({tag, "_rresp"}, RRESP, exp_resp);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk({tag, "_rvalid_drop"}, RVALID, 1'b0);
  endtask

  initial begin
    aresetn = 1'b0;
    AWADDR = '0; WDATA = '0; ARADDR = '0; WSTRB = '0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    AWPROT = 3'b000; ARPROT = 3'b000;
    exp_regs = '0;

    // Reset state
    tick();
    tick();
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_rresp", RRESP, 2'b00);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_pulse", wr_pulse_o, 16'h0);
    chk("rst_regs", reg_o, exp_regs);
    aresetn = 1'b1;
    tick();
    chk("rel_awready", AWREADY, 1'b1);
    chk("rel_wready", WREADY, 1'b1);
    chk("rel_arready", ARREADY, 1'b1);

    // Same-cycle AW+W to 0x8
    AWADDR = 32'h8; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t1_awready_full", AWREADY, 1'b0);
    chk("t1_wready_full", WREADY, 1'b0);
    chk("t1_bvalid_early", BVALID, 1'b0);
    tick();
    exp_regs[2*32 +: 32] = 32'hDEADBEEF;
    chk("t1_bvalid", BVALID, 1'b1);
    chk("t1_bresp", BRESP, 2'b00);
    chk("t1_pulse", wr_pulse_o, 16'h0004);
    chk("t1_regs", reg_o, exp_regs);
    tick();
    chk("t1_bvalid_drop", BVALID, 1'b0);
    chk("t1_pulse_drop", wr_pulse_o, 16'h0000);
    chk("t1_awready_back", AWREADY, 1'b1);
    rd_check("t1_rd", 32'h8, 32'hDEADBEEF, 2'b00);

    // W ahead of AW, partial strobes; a second W is refused while full
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
    tick();
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
    chk("t2_wready_full0", WREADY, 1'b0);
    chk("t2_awready", AWREADY, 1'b1);
    tick();
    chk("t2_wready_full1", WREADY, 1'b0);
    chk("t2_bvalid_wait", BVALID, 1'b0);
    tick();
    WVALID = 1'b0;
    AWADDR = 32'h8; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("t2_bvalid_early", BVALID, 1'b0);
    tick();
    exp_regs[2*32 +: 32] = 32'hDE22BE44;
    chk("t2_bvalid", BVALID, 1'b1);
    chk("t2_bresp", BRESP, 2'b00);
    chk("t2_pulse", wr_pulse_o, 16'h0004);
    chk("t2_regs", reg_o, exp_regs);
    tick();
    chk("t2_bvalid_drop", BVALID, 1'b0);

    // Back-pressured B: second write waits in the buffers
    BREADY = 1'b0;
    AWADDR = 32'h0; WDATA = 32'h00000001; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    exp_regs[0 +: 32] = 32'h00000001;
    chk("t3_b1_valid", BVALID, 1'b1);
    chk("t3_b1_pulse", wr_pulse_o, 16'h0001);
    AWADDR = 32'hC; WDATA = 32'h000000A5;
    AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t3_awready_blk", AWREADY, 1'b0);
    chk("t3_wready_blk", WREADY, 1'b0);
    tick();
    tick();
    tick();
    chk("t3_b1_hold", BVALID, 1'b1);
    chk("t3_bresp_hold", BRESP, 2'b00);
    chk("t3_no_commit_regs", reg_o, exp_regs);
    chk("t3_no_commit_pulse", wr_pulse_o, 16'h0000);
    chk("t3_awready_still", AWREADY, 1'b0);
    BREADY = 1'b1;
    tick();
    chk("t3_b1_done", BVALID, 1'b0);
    tick();
    exp_regs[3*32 +: 32] = 32'h000000A5;
    chk("t3_b2_valid", BVALID, 1'b1);
    chk("t3_b2_resp", BRESP, 2'b00);
    chk("t3_b2_pulse", wr_pulse_o, 16'h0008);
    chk("t3_b2_regs", reg_o, exp_regs);
    tick();
    chk("t3_b2_done", BVALID, 1'b0);
    chk("t3_awready_back", AWREADY, 1'b1);

    // Out-of-range write and reads
    AWADDR = 32'h40; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    chk("t4_bvalid", BVALID, 1'b1);
    chk("t4_bresp", BRESP, 2'b10);
    chk("t4_pulse", wr_pulse_o, 16'h0000);
    chk("t4_regs", reg_o, exp_regs);
    tick();
    chk("t4_bvalid_drop", BVALID, 1'b0);
    rd_check("t4_rd_oor", 32'h40, 32'h0, 2'b10);
    rd_check("t4_rd_upper", 32'h80000008, 32'h0, 2'b10);
    rd_check("t4_rd_last", 32'h3C, 32'h0, 2'b00);
    rd_check("t4_rd_unaligned", 32'hA, 32'hDE22BE44, 2'b00);

    // Read and commit to 0x4 on the same edge
    AWADDR = 32'h4; WDATA = 32'h00000005; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    exp_regs[1*32 +: 32] = 32'h00000005;
    chk("t5_rvalid", RVALID, 1'b1);
    chk("t5_rdata_old", RDATA, 32'h0);
    chk("t5_bvalid", BVALID, 1'b1);
    chk("t5_regs", reg_o, exp_regs);
    RREADY = 1'b1; BREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("t5_bvalid_drop", BVALID, 1'b0);
    rd_check("t5_rd_new", 32'h4, 32'h00000005, 2'b00);

    // Back-to-back reads with RREADY held high: one per two cycles
    ARADDR = 32'h0; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    chk("bb_rvalid0", RVALID, 1'b1);
    chk("bb_rdata0", RDATA, 32'h00000001);
    chk("bb_arready0", ARREADY, 1'b0);
    tick();
    chk("bb_rvalid1", RVALID, 1'b0);
    chk("bb_arready1", ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    chk("bb_rvalid2", RVALID, 1'b1);
    tick();
    RREADY = 1'b0;
    chk("bb_rvalid3", RVALID, 1'b0);

    // Reset while a read response is pending and AW is buffered
    ARADDR = 32'h8; ARVALID = 1'b1; RREADY = 1'b0; BREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk("t6_rvalid_pre", RVALID, 1'b1);
    AWADDR = 32'h10; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("t6_aw_full_pre", AWREADY, 1'b0);
    aresetn = 1'b0;
    #1;
    exp_regs = '0;
    chk("t6_rvalid_rst", RVALID, 1'b0);
    chk("t6_awready_rst", AWREADY, 1'b0);
    chk("t6_regs_rst", reg_o, exp_regs);
    tick();
    aresetn = 1'b1;
    tick();
    chk("t6_awready_rel", AWREADY, 1'b1);
    chk("t6_wready_rel", WREADY, 1'b1);
    WDATA = 32'h00000077; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    tick();
    tick();
    chk("t6_no_stale_b", BVALID, 1'b0);
    chk("t6_no_stale_regs", reg_o, exp_regs);
    chk("t6_no_stale_pulse", wr_pulse_o, 16'h0000);
    AWADDR = 32'h10; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    tick();
    exp_regs[4*32 +: 32] = 32'h00000077;
    chk("t6_bvalid", BVALID, 1'b1);
    chk("t6_pulse", wr_pulse_o, 16'h0010);
    chk("t6_regs", reg_o, exp_regs);
    tick();
    chk("t6_bvalid_drop", BVALID, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
- AXI4-Lite responder: a bank of NUM_REGS read/write registers, each DATA_WIDTH bits wide.
- Sits on the slave end of an axi4_lite link.
- Exposes register contents, plus a per-register write pulse, to fabric logic.
- Decouples the AW and W channels with single-entry holding buffers.
- Supports one outstanding write response and one outstanding read response.

Parameters:
DATA_WIDTH, 32, bus data width; only 32 or 64 are legal. ADDR_WIDTH is 32 or 64 to match. STRB_WIDTH = DATA_WIDTH/8.
NUM_REGS, 16, number of registers; must be >= 1.
RESET_VALUE, 0, reset value of every register (DATA_WIDTH bits).

Ports:
aclk  in  1  clock; all logic on the rising edge
aresetn  in  1  asynchronous, active-low reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWPROT  in  3  ignored
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  STRB_WIDTH  byte enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARPROT  in  3  ignored
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read valid
RREADY  in  1  read response ready
reg_o  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse_o  out  NUM_REGS  one-cycle pulse per register on a committed write

Behaviour:
- Reset (aresetn low, asynchronous):
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, wr_pulse_o=0.
  - All registers = RESET_VALUE; both holding buffers empty.
  - AWREADY=0, WREADY=0, ARREADY=0 while aresetn is low.
  - From the first edge after deassertion: AWREADY=1, WREADY=1, ARREADY=1.
  - Reset mid-transaction drops all buffered and pending state; no response is issued.
- Address decode:
  - ADDR_LSB = log2(STRB_WIDTH); index = addr >> ADDR_LSB; the low ADDR_LSB bits are ignored (unaligned accesses are treated as aligned).
  - In range iff index < NUM_REGS; all upper address bits take part in the compare.
- Write path:
  - aw_full and w_full flags; AWREADY = !aw_full, WREADY = !w_full.
  - A handshake (VALID&READY) captures AWADDR or WDATA/WSTRB and sets the corresponding flag. AW and W may arrive in either order or in the same cycle.
  - Commit occurs on the edge where aw_full & w_full & !BVALID:
    - In range: the register is updated byte-wise where WSTRB is set; wr_pulse_o[index]=1 for the following cycle; BRESP=00 (OKAY).
    - Out of range: no register changes, no pulse; BRESP=10 (SLVERR).
    - BVALID=1 from the cycle after commit; both flags clear.
  - Latency: AW and W handshaken at edge N -> BVALID visible after edge N+1.
  - BVALID holds, with BRESP stable, until BVALID&BREADY.
  - Pending BVALID blocks commit; the buffers stay full, so AWREADY and WREADY stay low.
  - WSTRB=0 in range: the commit is OKAY, the register is unchanged, and the pulse still fires.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake at edge N: RDATA/RRESP are registered and RVALID=1 after edge N.
    - In range: register value, RRESP=00.
    - Out of range: RDATA=0, RRESP=10.
  - RVALID/RDATA/RRESP hold until RVALID&RREADY; ARREADY=1 again the cycle after that handshake.
  - If RREADY=1 in the cycle RVALID rises, back-to-back reads sustain one transaction per two cycles.
- Simultaneous read and commit to the same register on the same edge: the read returns the pre-write value.
- Read and write paths are fully independent; there is no ordering between them.

Decomposition:
- Package axi4_lite_pkg:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10.
  - Functions addr_width(dw) and strb_width(dw).
- Sub-module axi4_lite_wr_buffer: single-entry holding register with valid flag, ready=!full, a load and a clear input. Instantiated twice, once for AW and once for W. The read path is inline.

Test Plan:
- Reset, then write AWADDR=0x8, WDATA=0xDEADBEEF, WSTRB=4'hF in the same cycle with BREADY=1 -> BVALID one cycle after commit with BRESP=00; wr_pulse_o[2]=1 for one cycle; reg_o word2=0xDEADBEEF; read of 0x8 returns 0xDEADBEEF, RRESP=00.
- W presented 3 cycles before AW, then a write with WSTRB=4'b0101, data 0x11223344, over 0xDEADBEEF -> register=0xDE22BE44; a second WVALID while w_full sees WREADY=0.
- Hold BREADY=0 for 5 cycles after a write, then issue a second AW+W -> both captured, AWREADY/WREADY=0, no second commit until B is handshaken; two responses arrive in order.
- Write and read to 0x40 with NUM_REGS=16 -> BRESP=10, RDATA=0, RRESP=10; no reg_o change, no pulse.
- AR to 0x4 on the same edge as a commit to 0x4 (old value 0, new value 0x5) -> RDATA=0; a subsequent read returns 0x5.
- Assert aresetn=0 while RVALID=1 and aw_full=1 -> RVALID=0 immediately, buffers clear, registers = RESET_VALUE; no stale B response after release.
